// File: rtl/stdp_update_scheduler_pkg.sv
// Shared types and helpers for the STDP update scheduler: FSM states,
// index-width helper and the saturating timer increment.
package stdp_update_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Timers stick at vmax so a long-silent input never wraps into the window.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
    return (v >= vmax) ? vmax : v + 32'd1;
  endfunction

endpackage

// File: rtl/stdp_update_scheduler_if.sv
// Spike inputs, weight read port and update-notification outputs of the
// STDP scheduler, bundled with master (driver) and slave (scheduler) views.
interface stdp_update_scheduler_if
  import stdp_update_scheduler_pkg::*;
#(
  parameter int N_SYN = 4,
  parameter int WW    = 8
) ();
  localparam int IW = idx_w(N_SYN);

  logic [N_SYN-1:0] pre_spike;
  logic             post_spike;
  logic             learn_en;
  logic [IW-1:0]    rd_idx;
  logic [WW-1:0]    rd_weight;
  logic             busy;
  logic             upd_valid;
  logic [IW-1:0]    upd_idx;
  logic             upd_ltp;

  modport master (
    output pre_spike, post_spike, learn_en, rd_idx,
    input  rd_weight, busy, upd_valid, upd_idx, upd_ltp
  );

  modport slave (
    input  pre_spike, post_spike, learn_en, rd_idx,
    output rd_weight, busy, upd_valid, upd_idx, upd_ltp
  );
endinterface

// File: rtl/stdp_update_scheduler_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping,
// returned as a one-hot grant plus its binary index.
module stdp_update_scheduler_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW-1:0] cand;
  logic          found;

  // N is a power of two, so IW-bit wrap-around gives the modulo for free.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr_i + IW'(k);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        grant_o[cand]  = 1'b1;
        idx_o          = cand;
      end
    end
  end

  assign any_o = |req_i;
endmodule

// File: rtl/stdp_update_scheduler.sv
// STDP learning controller: per-synapse pairing timers queue LTP/LTD events,
// which a round-robin FSM serialises onto one weight-update datapath.
module stdp_update_scheduler
  import stdp_update_scheduler_pkg::*;
#(
  parameter int N_SYN  = 4,
  parameter int TW     = 8,
  parameter int WW     = 8,
  parameter int WINDOW = 16,
  parameter int A_MAX  = 8,
  parameter int W_INIT = 16,
  parameter int W_MAX  = 255
) (
  input logic                   clk,
  input logic                   rst_n,
  stdp_update_scheduler_if.slave bus
);
  localparam int          IW    = idx_w(N_SYN);
  localparam logic [31:0] T_MAX = 32'((2 ** TW) - 1);
  localparam logic [31:0] WIN   = 32'(WINDOW);
  localparam logic [WW:0] WMAX  = (WW+1)'(W_MAX);

  logic [TW-1:0]    pre_t_q [N_SYN];
  logic [TW-1:0]    pre_t_d [N_SYN];
  logic [TW-1:0]    post_t_q, post_t_d;
  logic [TW-1:0]    ltp_dt_q [N_SYN];
  logic [TW-1:0]    ltp_dt_d [N_SYN];
  logic [TW-1:0]    ltd_dt_q [N_SYN];
  logic [TW-1:0]    ltd_dt_d [N_SYN];
  logic [N_SYN-1:0] ltp_pend_q, ltp_pend_d, ltd_pend_q, ltd_pend_d;
  logic [N_SYN-1:0] ltp_set, ltd_set, req, grant;
  logic [WW-1:0]    weight_q [N_SYN];

  state_t        state_q;
  logic [IW-1:0] idx_q, rr_ptr_q, upd_idx_q, gnt_idx;
  logic          ltp_q, upd_valid_q, upd_ltp_q, gnt_any, take;
  logic [TW-1:0] dt_q;
  logic [WW-1:0] nw_q;
  logic [WW:0]   delta, w_ext, sum, nw_calc;

  assign take     = (state_q == S_IDLE) && gnt_any;
  assign post_t_d = bus.post_spike ? '0 : TW'(sat_inc(32'(post_t_q), T_MAX));

  // Capture reads timer values from before this edge; a set wins over a grant-clear.
  for (genvar gi = 0; gi < N_SYN; gi++) begin : g_syn
    assign pre_t_d[gi]    = bus.pre_spike[gi] ? '0 : TW'(sat_inc(32'(pre_t_q[gi]), T_MAX));
    assign ltp_set[gi]    = bus.learn_en & bus.post_spike & ~bus.pre_spike[gi] & (32'(pre_t_q[gi]) < WIN);
    assign ltd_set[gi]    = bus.learn_en & bus.pre_spike[gi] & ~bus.post_spike & (32'(post_t_q) < WIN);
    assign ltp_pend_d[gi] = ltp_set[gi] | (ltp_pend_q[gi] & ~(take & grant[gi]));
    assign ltd_pend_d[gi] = ltd_set[gi] | (ltd_pend_q[gi] & ~(take & grant[gi] & ~ltp_pend_q[gi]));
    assign ltp_dt_d[gi]   = ltp_set[gi] ? pre_t_q[gi] : ltp_dt_q[gi];
    assign ltd_dt_d[gi]   = ltd_set[gi] ? post_t_q : ltd_dt_q[gi];
    assign req[gi]        = ltp_pend_q[gi] | ltd_pend_q[gi];
  end

  stdp_update_scheduler_rr_arbiter #(.N(N_SYN), .IW(IW)) u_arb (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_t_q   <= '1;
      ltp_pend_q <= '0;
      ltd_pend_q <= '0;
      for (int i = 0; i < N_SYN; i++) begin
        pre_t_q[i]  <= '1;
        ltp_dt_q[i] <= '0;
        ltd_dt_q[i] <= '0;
        weight_q[i] <= WW'(W_INIT);
      end
    end else begin
      post_t_q   <= post_t_d;
      ltp_pend_q <= ltp_pend_d;
      ltd_pend_q <= ltd_pend_d;
      for (int i = 0; i < N_SYN; i++) begin
        pre_t_q[i]  <= pre_t_d[i];
        ltp_dt_q[i] <= ltp_dt_d[i];
        ltd_dt_q[i] <= ltd_dt_d[i];
      end
      if (state_q == S_WRITE) weight_q[idx_q] <= nw_q;
    end
  end

  // One extra bit absorbs the overflow/underflow before clamping.
  assign delta = (WW+1)'(A_MAX) >> (dt_q >> 2);
  assign w_ext = {1'b0, weight_q[idx_q]};
  assign sum   = w_ext + delta;

  always_comb begin
    nw_calc = w_ext;
    if (ltp_q) nw_calc = (sum > WMAX) ? WMAX : sum;
    else       nw_calc = (w_ext < delta) ? '0 : w_ext - delta;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ltp_q       <= 1'b0;
      dt_q        <= '0;
      nw_q        <= '0;
      rr_ptr_q    <= '0;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_ltp_q   <= 1'b0;
    end else begin
      upd_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_any) begin
            idx_q   <= gnt_idx;
            ltp_q   <= ltp_pend_q[gnt_idx];
            dt_q    <= ltp_pend_q[gnt_idx] ? ltp_dt_q[gnt_idx] : ltd_dt_q[gnt_idx];
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          nw_q    <= WW'(nw_calc);
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          upd_valid_q <= 1'b1;
          upd_idx_q   <= idx_q;
          upd_ltp_q   <= ltp_q;
          rr_ptr_q    <= idx_q + IW'(1);
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_weight = weight_q[bus.rd_idx];
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.upd_valid = upd_valid_q;
  assign bus.upd_idx   = upd_idx_q;
  assign bus.upd_ltp   = upd_ltp_q;
endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Directed bench for stdp_update_scheduler: pairing, round-robin order,
// window boundary, clamping and mid-update reset, with hand-computed weights.
module tb_stdp_update_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cap_cyc;

  typedef struct {
    int idx;
    int ltp;
    int cyc;
  } ev_t;
  ev_t ev_q[$];

  stdp_update_scheduler_if #(.N_SYN(4), .WW(8)) bus ();

  stdp_update_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.upd_valid) begin
      ev_q.push_back('{idx: int'(bus.upd_idx), ltp: int'(bus.upd_ltp), cyc: cyc});
      $display("upd cyc=%0d idx=%0d ltp=%0d", cyc, bus.upd_idx, bus.upd_ltp);
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] pre, input logic post);
    bus.pre_spike  = pre;
    bus.post_spike = post;
    @(posedge clk);
    #1;
    bus.pre_spike  = '0;
    bus.post_spike = 1'b0;
  endtask

  task automatic check_w(input int i, input int exp, input string tag);
    bus.rd_idx = 2'(i);
    #1;
    check_val(tag, int'(bus.rd_weight), exp);
  endtask

  // Timer value seen by the capturing edge equals gap.
  task automatic ltp_train(input int i, input int gap);
    pulse(4'(1 << i), 1'b0);
    idle(gap);
    pulse(4'b0000, 1'b1);
    idle(20);
  endtask

  task automatic ltd_train(input int i, input int gap);
    pulse(4'b0000, 1'b1);
    idle(gap);
    pulse(4'(1 << i), 1'b0);
    idle(20);
  endtask

  function automatic int ev_idx(input int k);
    return (k < ev_q.size()) ? ev_q[k].idx : -1;
  endfunction

  function automatic int ev_ltp(input int k);
    return (k < ev_q.size()) ? ev_q[k].ltp : -1;
  endfunction

  function automatic int ev_cyc(input int k);
    return (k < ev_q.size()) ? ev_q[k].cyc : -1;
  endfunction

  initial begin
    bus.pre_spike  = '0;
    bus.post_spike = 1'b0;
    bus.learn_en   = 1'b1;
    bus.rd_idx     = '0;
    idle(3);
    check_val("rst_busy", int'(bus.busy), 0);
    check_val("rst_upd_valid", int'(bus.upd_valid), 0);
    check_val("rst_upd_idx", int'(bus.upd_idx), 0);
    for (int i = 0; i < 4; i++) check_w(i, 16, $sformatf("rst_w%0d", i));
    rst_n = 1'b1;
    idle(3);

    // 1: pre[0] then post three edges later -> LTP, dt=2, +8
    ev_q.delete();
    pulse(4'b0001, 1'b0);
    idle(2);
    pulse(4'b0000, 1'b1);
    cap_cyc = cyc;
    idle(20);
    check_val("t1_count", ev_q.size(), 1);
    check_val("t1_idx", ev_idx(0), 0);
    check_val("t1_ltp", ev_ltp(0), 1);
    check_val("t1_latency", ev_cyc(0) - cap_cyc, 3);
    check_w(0, 24, "t1_w0");

    // 2: post then pre[1] nine edges later -> LTD, dt=8, -2
    ev_q.delete();
    ltd_train(1, 8);
    check_val("t2_count", ev_q.size(), 1);
    check_val("t2_idx", ev_idx(0), 1);
    check_val("t2_ltp", ev_ltp(0), 0);
    check_w(1, 14, "t2_w1");

    // 3: two synapses paired together, rr_ptr=2 -> 2 then 3
    ev_q.delete();
    pulse(4'b1100, 1'b0);
    pulse(4'b0000, 1'b1);
    idle(20);
    check_val("t3_count", ev_q.size(), 2);
    check_val("t3_first", ev_idx(0), 2);
    check_val("t3_second", ev_idx(1), 3);
    check_val("t3_spacing", ev_cyc(1) - ev_cyc(0), 3);
    check_w(2, 24, "t3_w2");
    check_w(3, 24, "t3_w3");
    ltp_train(2, 0);
    check_w(2, 32, "t3_w2_single");
    ev_q.delete();
    pulse(4'b1100, 1'b0);
    pulse(4'b0000, 1'b1);
    idle(20);
    check_val("t3b_first", ev_idx(0), 3);
    check_val("t3b_second", ev_idx(1), 2);
    check_w(3, 32, "t3b_w3");
    check_w(2, 40, "t3b_w2");

    // 4: same-cycle pair, out-of-window pair, learn disabled, window edge
    ev_q.delete();
    pulse(4'b0001, 1'b1);
    idle(20);
    check_val("t4_same_cycle", ev_q.size(), 0);
    ltp_train(0, 16);
    check_val("t4_dt16", ev_q.size(), 0);
    bus.learn_en = 1'b0;
    ltp_train(0, 0);
    bus.learn_en = 1'b1;
    check_val("t4_learn_off", ev_q.size(), 0);
    ltp_train(0, 15);
    check_val("t4_dt15_count", ev_q.size(), 1);
    check_w(0, 25, "t4_dt15_w0");

    // 5: clamp at both ends
    ltp_train(0, 15);
    repeat (28) ltp_train(0, 0);
    check_w(0, 250, "t5_w0_250");
    ltp_train(0, 0);
    check_w(0, 255, "t5_w0_clamp");
    ltd_train(1, 0);
    repeat (3) ltd_train(1, 15);
    check_w(1, 3, "t5_w1_3");
    ltd_train(1, 0);
    check_w(1, 0, "t5_w1_clamp");

    // 6: reset while the FSM sits in S_CALC
    ev_q.delete();
    pulse(4'b0100, 1'b0);
    pulse(4'b0000, 1'b1);
    idle(1);
    check_val("t6_busy_calc", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check_val("t6_busy_rst", int'(bus.busy), 0);
    check_w(0, 16, "t6_w0_rst");
    check_w(2, 16, "t6_w2_rst");
    idle(2);
    rst_n = 1'b1;
    idle(10);
    check_val("t6_no_update", ev_q.size(), 0);
    check_w(2, 16, "t6_w2_after");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
